psram_port_arbiter: RTL and testbench

- Shares one PSRAM channel command interface (cmd / cmd_en / addr / wr_data / data_mask / rd_data / rd_data_valid) between an instruction-fetch requester (read-only) and a data requester (read/write).
- Sits between the CPU memory stage and one channel of the 2-channel HS PSRAM interface, clocked by the interface user clock.
- Sequences each transaction (issue, read wait, write recovery) and round-robins between requesters.

---
 rtl/psram_pkg.sv | 38 +++
 rtl/psram_rr_pick.sv | 25 ++
 rtl/psram_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_psram_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package psram_pkg;

    // Channel sequencing states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        WR_HOLD = 2'd3
    } state_t;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic       CMD_RD    = 1'b0;
    localparam logic       CMD_WR    = 1'b1;
    localparam logic [3:0] MASK_NONE = 4'hF;

    // Everything latched at grant time except the address, whose width
    // depends on the top-level parameter.
    typedef struct packed {
        owner_t      owner;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    // 8-bit counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/psram_rr_pick.sv
// Two-way round-robin selector between instruction fetch and data requester.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller qualifies req with its own readiness.
//
// Ports:
//   req[0] = ifetch request, req[1] = data request
//   last_grant = owner granted most recently
//   grant = one-hot (or zero) grant vector, same bit order as req
module psram_rr_pick
    import psram_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // On a tie the requester that did not win last time goes first.
        if (req == 2'b11) begin
            grant = (last_grant == OWN_D) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/psram_port_arbiter.sv
// Shares one PSRAM channel between an ifetch reader and a data read/write port.
// Latency: ack in grant cycle, cmd_en next cycle, rvalid one cycle after mem_rd_valid.
// Backpressure: requests are held until acked; only one transaction in flight,
//               no grant while calib_done is low or outside IDLE.
//
// Ports:
//   clk, reset         user clock, synchronous active-high reset
//   calib_done         PSRAM calibration finished; gates all grants
//   if_*               ifetch port: req/addr in, ack/rdata/rvalid out
//   d_*                data port: req/we/addr/wdata/be in, ack/rdata/rvalid out
//   mem_*              PSRAM channel command interface
//   err_timeout        pulse when a read is abandoned without data
module psram_port_arbiter
    import psram_pkg::*;
#(
    parameter int ADDR_W     = 21,
    parameter int WR_CYCLES  = 14,  // must be 2..255
    parameter int RD_TIMEOUT = 64   // must be 2..255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              calib_done,
    input  logic              if_req,
    input  logic [ADDR_W-3:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-3:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_rvalid,
    output logic              mem_cmd,
    output logic              mem_cmd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic [3:0]        mem_data_mask,
    input  logic [31:0]       mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              err_timeout
);

    // Counter values on which the wait states end; the counter reads 1 in the
    // first cycle after cmd_en, so it equals cycles elapsed since cmd_en.
    localparam logic [7:0] RD_LAST = 8'(RD_TIMEOUT - 1);
    localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);

    state_t            state_q,     state_d;
    owner_t            last_q,      last_d;
    txn_t              txn_q,       txn_d;
    logic [ADDR_W-3:0] addr_q,      addr_d;
    logic [7:0]        cnt_q,       cnt_d;
    logic [31:0]       if_rdata_q,  if_rdata_d;
    logic [31:0]       d_rdata_q,   d_rdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q,  d_rvalid_d;
    logic              err_q,       err_d;

    logic [1:0] req_v;
    logic [1:0] grant;

    // Reset is folded in so the combinational acks stay low during reset.
    assign req_v = {d_req, if_req} & {2{calib_done & ~reset}};

    psram_rr_pick u_rr_pick (
        .req        (req_v),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        txn_d         = txn_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        if_rvalid_d   = 1'b0;
        d_rvalid_d    = 1'b0;
        err_d         = 1'b0;
        if_ack        = 1'b0;
        d_ack         = 1'b0;
        mem_cmd_en    = 1'b0;
        mem_cmd       = CMD_RD;
        mem_addr      = '0;
        mem_wr_data   = '0;
        mem_data_mask = MASK_NONE;

        case (state_q)
            IDLE: begin
                if (grant[0]) begin
                    if_ack  = 1'b1;
                    last_d  = OWN_IF;
                    addr_d  = if_addr;
                    txn_d   = '{owner: OWN_IF, we: CMD_RD, wdata: '0, be: '0};
                    state_d = ISSUE;
                end else if (grant[1]) begin
                    d_ack  = 1'b1;
                    last_d = OWN_D;
                    // A write with no enabled bytes has nothing to do; it is
                    // acknowledged and the channel stays free.
                    if (!(d_we && (d_be == 4'h0))) begin
                        addr_d  = d_addr;
                        txn_d   = '{owner: OWN_D, we: d_we, wdata: d_wdata, be: d_be};
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                mem_cmd_en    = 1'b1;
                mem_cmd       = txn_q.we;
                mem_addr      = {addr_q, 2'b00};
                mem_wr_data   = txn_q.wdata;
                mem_data_mask = txn_q.we ? ~txn_q.be : 4'h0;
                cnt_d         = 8'd1;
                state_d       = txn_q.we ? WR_HOLD : RD_WAIT;
            end

            RD_WAIT: begin
                if (mem_rd_valid) begin
                    if (txn_q.owner == OWN_IF) begin
                        if_rdata_d  = mem_rd_data;
                        if_rvalid_d = 1'b1;
                    end else begin
                        d_rdata_d  = mem_rd_data;
                        d_rvalid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (cnt_q >= RD_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = sat_inc8(cnt_q);
                end
            end

            WR_HOLD: begin
                if (cnt_q >= WR_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = sat_inc8(cnt_q);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= OWN_D;
            txn_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            txn_q       <= txn_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            err_q       <= err_d;
        end
    end

    assign if_rdata    = if_rdata_q;
    assign if_rvalid   = if_rvalid_q;
    assign d_rdata     = d_rdata_q;
    assign d_rvalid    = d_rvalid_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Directed bench for psram_port_arbiter with a small PSRAM read-latency model.
// Latency: n/a.
// Backpressure: n/a.
module tb_psram_port_arbiter;

    localparam int ADDR_W = 21;

    logic              clk = 1'b0;
    logic              reset;
    logic              calib_done;
    logic              if_req;
    logic [ADDR_W-3:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              if_rvalid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-3:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_be;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_rvalid;
    logic              mem_cmd;
    logic              mem_cmd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic [3:0]        mem_data_mask;
    logic [31:0]       mem_rd_data  = 32'h0;
    logic              mem_rd_valid = 1'b0;
    logic              err_timeout;

    always #5 clk = ~clk;

    psram_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .WR_CYCLES  (14),
        .RD_TIMEOUT (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .calib_done    (calib_done),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_ack        (if_ack),
        .if_rdata      (if_rdata),
        .if_rvalid     (if_rvalid),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_be          (d_be),
        .d_ack         (d_ack),
        .d_rdata       (d_rdata),
        .d_rvalid      (d_rvalid),
        .mem_cmd       (mem_cmd),
        .mem_cmd_en    (mem_cmd_en),
        .mem_addr      (mem_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_data_mask (mem_data_mask),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_valid  (mem_rd_valid),
        .err_timeout   (err_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // PSRAM read model: a read cmd_en in cycle C returns rd_word with
    // mem_rd_valid in cycle C+rd_lat; rd_lat == 0 means never answer.
    int          rd_lat  = 0;
    logic [31:0] rd_word = 32'h0;
    int          pend    = 0;

    always @(negedge clk) begin
        mem_rd_valid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = rd_word;
            end
        end
        if (mem_cmd_en && !mem_cmd && rd_lat > 0) pend = rd_lat;
    end

    // Event counters and grant log.
    int n_if_ack = 0, n_d_ack = 0, n_if_rv = 0, n_d_rv = 0, n_cmd = 0, n_dbl = 0, cyc = 0;
    bit prev_if_ack = 1'b0, prev_d_ack = 1'b0;
    int ack_cyc[$];
    bit ack_own[$];

    always @(negedge clk) begin
        cyc++;
        if (if_ack) begin n_if_ack++; ack_own.push_back(1'b0); ack_cyc.push_back(cyc); end
        if (d_ack)  begin n_d_ack++;  ack_own.push_back(1'b1); ack_cyc.push_back(cyc); end
        if ((if_ack && prev_if_ack) || (d_ack && prev_d_ack)) n_dbl++;
        prev_if_ack = if_ack;
        prev_d_ack  = d_ack;
        if (if_rvalid)  n_if_rv++;
        if (d_rvalid)   n_d_rv++;
        if (mem_cmd_en) n_cmd++;
    end

    initial begin
        int got;
        int base0, base1, base2;
        bit ack_at_err;

        reset = 1'b1; calib_done = 1'b0;
        if_req = 1'b1; if_addr = 19'h10000;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = 4'h0;

        // Reset and calibration gating.
        repeat (3) step();
        chk("rst_ctl", {if_ack, d_ack, if_rvalid, d_rvalid, mem_cmd_en, err_timeout, mem_cmd}, 0);
        chk("rst_mask", mem_data_mask, 4'hF);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        chk("rst_addr", mem_addr, 0);
        reset = 1'b0;
        repeat (2) step();
        chk("nocal_ack", if_ack, 0);
        chk("nocal_cmd", mem_cmd_en, 0);
        chk("nocal_mask", mem_data_mask, 4'hF);

        // Ifetch read, data returned 5 cycles after cmd_en.
        rd_lat = 5; rd_word = 32'hDEADBEEF;
        calib_done = 1'b1;
        #1;
        chk("cal_if_ack", if_ack, 1);
        step();
        if_req = 1'b0;
        chk("ifrd_cmd_en", mem_cmd_en, 1);
        chk("ifrd_addr", mem_addr, 21'h40000);
        chk("ifrd_cmd", mem_cmd, 0);
        chk("ifrd_mask", mem_data_mask, 4'h0);
        got = 0;
        for (int i = 1; i <= 20 && got == 0; i++) begin
            step();
            if (if_rvalid) got = i;
        end
        chk("ifrd_lat", got, 6);
        chk("ifrd_data", if_rdata, 32'hDEADBEEF);
        step();
        chk("ifrd_pulse", if_rvalid, 0);
        chk("ifrd_hold", if_rdata, 32'hDEADBEEF);
        chk("ifrd_count", n_if_rv, 1);

        // Data write; a pending ifetch must wait for the whole write window.
        d_req = 1'b1; d_we = 1'b1; d_addr = 19'h4; d_wdata = 32'h12345678; d_be = 4'b0011;
        #1;
        chk("wr_ack", d_ack, 1);
        step();
        d_req = 1'b0; if_req = 1'b1; if_addr = 19'h00123; rd_lat = 3;
        chk("wr_cmd_en", mem_cmd_en, 1);
        chk("wr_cmd", mem_cmd, 1);
        chk("wr_addr", mem_addr, 21'h10);
        chk("wr_mask", mem_data_mask, 4'b1100);
        chk("wr_data", mem_wr_data, 32'h12345678);
        got = 0;
        for (int i = 1; i <= 20 && got == 0; i++) begin
            step();
            if (i == 5) chk("wr_hold_mask", {mem_cmd_en, mem_data_mask}, 5'h0F);
            if (if_ack) got = i;
        end
        chk("wr_busy", got, 14);
        step();
        if_req = 1'b0;
        repeat (10) step();
        chk("wr_then_if", n_if_rv, 2);

        // Contention after reset: IF, D, IF, D, back to back every 4 cycles.
        reset = 1'b1;
        repeat (2) step();
        ack_own.delete(); ack_cyc.delete(); n_dbl = 0;
        rd_lat = 2; rd_word = 32'hA5A5_0001;
        d_we = 1'b0; d_addr = 19'h55; d_be = 4'hF;
        if_req = 1'b1; d_req = 1'b1;
        reset = 1'b0;
        repeat (20) step();
        if_req = 1'b0; d_req = 1'b0;
        repeat (10) step();
        chk("cont_count", ack_own.size() >= 4, 1);
        if (ack_own.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("cont_order%0d", i), ack_own[i], i % 2);
                if (i > 0) chk($sformatf("cont_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 4);
            end
        end
        chk("cont_single", n_dbl, 0);

        // Data read that never returns; pending ifetch goes next.
        rd_lat = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 19'h77;
        #1;
        chk("to_d_ack", d_ack, 1);
        step();
        d_req = 1'b0;
        chk("to_cmd_en", mem_cmd_en, 1);
        if_req = 1'b1; if_addr = 19'h200;
        base0 = n_d_rv; base1 = n_if_ack; base2 = n_if_rv;
        got = 0; ack_at_err = 1'b0;
        for (int i = 1; i <= 80 && got == 0; i++) begin
            step();
            if (err_timeout) begin got = i; ack_at_err = if_ack; end
        end
        chk("to_lat", got, 64);
        chk("to_no_early_ack", n_if_ack - base1, 0);
        chk("to_if_ack", ack_at_err, 1);
        rd_lat = 3; rd_word = 32'h0BAD_F00D;
        step();
        if_req = 1'b0;
        chk("to_err_pulse", err_timeout, 0);
        repeat (8) step();
        chk("to_no_d_rvalid", n_d_rv - base0, 0);
        chk("to_if_done", n_if_rv - base2, 1);
        chk("to_if_data", if_rdata, 32'h0BAD_F00D);

        // Write with no byte enables: acked, nothing issued.
        base0 = n_cmd;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = 19'h9;
        #1;
        chk("be0_ack", d_ack, 1);
        step();
        d_req = 1'b0;
        chk("be0_no_cmd", mem_cmd_en, 0);
        repeat (3) step();
        chk("be0_cmd_count", n_cmd - base0, 0);

        // Reset while waiting for read data; the late data is ignored.
        rd_lat = 5; rd_word = 32'hCAFEF00D;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 19'h30;
        #1;
        chk("rstrd_ack", d_ack, 1);
        base0 = n_d_rv;
        step();
        d_req = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (8) step();
        chk("rstrd_no_rvalid", n_d_rv - base0, 0);
        chk("rstrd_rdata", d_rdata, 0);
        if_req = 1'b1; if_addr = 19'h1;
        #1;
        chk("rstrd_idle", if_ack, 1);
        step();
        if_req = 1'b0;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
